// File: rtl/seq_divider_if.sv
// Start/done request bundle between the execute stage and seq_divider.
// Master is the pipeline side; slave is the divider.
interface seq_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring radix-2 divider, RV32M DIV/DIVU/REM/REMU semantics.
// DIV_EARLY_OUT_EN: zero-divisor and signed-overflow skip CALC.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem;
  logic [N-1:0] quo;
  logic [N-1:0] dmag;
  logic [N-1:0] a_raw;
  logic         neg_q;
  logic         neg_r;
  logic         dz;
  logic         ovf;
  logic [N-1:0] q_r;
  logic [N-1:0] r_r;
  logic         dz_r;
  logic         done_r;
  logic         busy_r;

  logic         a_neg;
  logic         b_neg;
  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;
  logic         in_dz;
  logic         in_ovf;
  logic [N:0]   shl;
  logic [N:0]   diff;
  logic [N-1:0] q_fix;
  logic [N-1:0] r_fix;

  assign a_neg  = bus.is_signed & bus.dividend[N-1];
  assign b_neg  = bus.is_signed & bus.divisor[N-1];
  assign a_abs  = a_neg ? -bus.dividend : bus.dividend;
  assign b_abs  = b_neg ? -bus.divisor : bus.divisor;
  assign in_dz  = (bus.divisor == '0);
  assign in_ovf = bus.is_signed
                & (bus.dividend == {1'b1, {(N-1){1'b0}}})
                & (bus.divisor == '1);

  // shl < 2*dmag, so diff[N] is set exactly when a borrow occurred
  assign shl  = {rem, quo[N-1]};
  assign diff = shl - {1'b0, dmag};

  always_comb begin
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
    if (dz) begin
      q_fix = '1;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = a_raw;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dmag   <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      dz_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_raw  <= bus.dividend;
            quo    <= a_abs;
            dmag   <= b_abs;
            rem    <= '0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= in_dz;
            ovf    <= in_ovf;
            cnt    <= CW'(N - 1);
            busy_r <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            state  <= (in_dz || in_ovf) ? FIX : CALC;
`else
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          quo <= {quo[N-2:0], ~diff[N]};
          if (!diff[N]) rem <= diff[N-1:0];
          else          rem <= shl[N-1:0];
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          q_r    <= q_fix;
          r_r    <= r_fix;
          dz_r   <= dz;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider, N=32.
// Results are queued at request time and popped on each done.
module tb_seq_divider;
  localparam int N = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int SP = 2;
`else
  localparam int SP = 34;
`endif

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } res_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   dn_cnt;
  res_t sb[$];

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic s, input logic [N-1:0] a,
                                 input logic [N-1:0] b);
    res_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0; e.dz = 1'b0;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
      e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic res_t mk(input logic [N-1:0] q, input logic [N-1:0] r,
                              input logic dz);
    res_t e;
    e.q = q; e.r = r; e.dz = dz;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      res_t e;
      res_t g;
      logic empty;
      dn_cnt++;
      empty = (sb.size() == 0);
      chk("sb_nonempty", 64'(empty), 64'd0);
      if (!empty) begin
        e = sb.pop_front();
        g = mk(bus.quotient, bus.remainder, bus.div_by_zero);
        chk("quo", 64'(g.q), 64'(e.q));
        chk("rem", 64'(g.r), 64'(e.r));
        chk("dz", 64'(g.dz), 64'(e.dz));
      end
    end
  end

  // Call at a negedge while the divider is idle; returns in the cycle after done.
  task automatic do_div(input string tag, input logic s,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input res_t e, input int exp_lat, input int glitch);
    int lat;
    int bcnt;
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    sb.push_back(e);
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.start = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      if (bus.busy) bcnt++;
      if (glitch != 0 && lat == glitch) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
      end
    end while (!bus.done && lat < 100);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy"}, 64'(bcnt), 64'(exp_lat));
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int d0;
    total = 0;
    bad = 0;
    dn_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", {29'd0, bus.busy, bus.done, bus.div_by_zero,
                      bus.quotient}, 64'd0);
    chk("rst_rem", 64'(bus.remainder), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_div("u100_7", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 34, 0);
    do_div("s-7_2", 1'b1, -32'sd7, 32'd2,
           mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 34, 0);
    do_div("s7_-2", 1'b1, 32'd7, -32'sd2,
           mk(32'hFFFF_FFFD, 32'd1, 1'b0), 34, 0);
    do_div("s5_0", 1'b1, 32'd5, 32'd0,
           mk(32'hFFFF_FFFF, 32'd5, 1'b1), SP, 0);
    do_div("u5_0", 1'b0, 32'd5, 32'd0,
           mk(32'hFFFF_FFFF, 32'd5, 1'b1), SP, 0);
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           mk(32'h8000_0000, 32'd0, 1'b0), SP, 0);
    do_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           mk(32'd0, 32'h8000_0000, 1'b0), 34, 0);
    do_div("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1,
           mk(32'hFFFF_FFFF, 32'd0, 1'b0), 34, 0);
    do_div("s_neg0", 1'b1, 32'hFFFF_FFF9, 32'd0,
           mk(32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1), SP, 0);

    d0 = dn_cnt;
    do_div("glitch", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0), 34, 5);
    chk("glitch_one_done", 64'(dn_cnt - d0), 64'd1);

    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [N-1:0] a;
      logic [N-1:0] b;
      s = i[0];
      a = $urandom;
      b = (i == 6) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 7) b = -32'sd3;
      do_div("rand", s, a, b, model(s, a, b), 34, 0);
    end

    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend = 32'd100;
    bus.divisor = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    d0 = dn_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_out", {29'd0, bus.busy, bus.done, bus.div_by_zero,
                      bus.quotient}, 64'd0);
    chk("abort_rem", 64'(bus.remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_nodone", 64'(dn_cnt - d0), 64'd0);

    do_div("u20_6", 1'b0, 32'd20, 32'd6, mk(32'd3, 32'd2, 1'b0), 34, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
